// File: rtl/fifo_lector.sv
// Read-side controller for the byte FIFO: waits for a fill threshold or timeout,
// then drains the FIFO through a 2-entry skid buffer onto a valid/ready stream.
module fifo_lector #(
    parameter int ANCHO     = 8,
    parameter int PROF_LOG2 = 5,
    parameter int UMBRAL    = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vacio,
    input  logic [PROF_LOG2-1:0] use_dw,
    input  logic [ANCHO-1:0]     dato_fifo,
    output logic                 read,
    output logic [ANCHO-1:0]     dato_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 ocupado,
    output logic [15:0]          n_leidos
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic {ESPERA, DRENANDO} estado_t;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ocup_q, ocup_d;
    logic             en_vuelo_q;
    logic [ANCHO-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [15:0]      n_leidos_q, n_leidos_d;
    logic             pop, disparo;
    logic [2:0]       carga;

    assign valid_out = (ocup_q != 2'd0);
    assign dato_out  = buf0_q;
    assign ocupado   = (estado_q == DRENANDO);
    assign n_leidos  = n_leidos_q;
    assign pop       = valid_out & ready_in;

    // Entries already committed (buffered + in flight); a pop this cycle frees one.
    assign carga = {1'b0, ocup_q} + {2'b0, en_vuelo_q};
    assign read  = (estado_q == DRENANDO) && !vacio && (carga < (3'd2 + {2'b0, pop}));

    // use_dw == 0 with vacio == 0 means the occupancy counter wrapped on a full FIFO.
    assign disparo = !vacio && ((use_dw >= PROF_LOG2'(UMBRAL)) || (use_dw == '0) ||
                                (cnt_q == CNT_W'(TIMEOUT - 1)));

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        case (estado_q)
            ESPERA: begin
                cnt_d = vacio ? '0 : cnt_q + CNT_W'(1);
                if (disparo) estado_d = DRENANDO;
            end
            default: begin
                cnt_d = '0;
                if (vacio) estado_d = ESPERA;
            end
        endcase
    end

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        ocup_d = ocup_q;
        case ({en_vuelo_q, pop})
            2'b10: begin
                if (ocup_q == 2'd0) buf0_d = dato_fifo;
                else                buf1_d = dato_fifo;
                ocup_d = ocup_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                ocup_d = ocup_q - 2'd1;
            end
            2'b11: begin
                if (ocup_q == 2'd1) begin
                    buf0_d = dato_fifo;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = dato_fifo;
                end
            end
            default: ;
        endcase
        n_leidos_d = n_leidos_q + {15'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= ESPERA;
            cnt_q      <= '0;
            ocup_q     <= 2'd0;
            en_vuelo_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            n_leidos_q <= '0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            ocup_q     <= ocup_d;
            en_vuelo_q <= read;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            n_leidos_q <= n_leidos_d;
        end
    end

endmodule
